mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter.sv | 158 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one memory port between instruction fetch and the LSU,
//            one outstanding transaction, with a fetch anti-starvation streak.
// Revision : 1.0 - initial release
// ============================================================================

module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  if_req_i,
    input  logic [ADDR_W-1:0]     if_addr_i,
    output logic                  if_gnt_o,
    output logic                  if_rvalid_o,
    output logic [DATA_W-1:0]     if_rdata_o,

    input  logic                  lsu_req_i,
    input  logic                  lsu_we_i,
    input  logic [DATA_W/8-1:0]   lsu_be_i,
    input  logic [ADDR_W-1:0]     lsu_addr_i,
    input  logic [DATA_W-1:0]     lsu_wdata_i,
    output logic                  lsu_gnt_o,
    output logic                  lsu_rvalid_o,
    output logic [DATA_W-1:0]     lsu_rdata_o,

    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [DATA_W/8-1:0]   mem_be_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic [DATA_W-1:0]     mem_wdata_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_W-1:0]     mem_rdata_i
);

    localparam int c_streak_w = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_streak_w-1:0] c_streak_max = c_streak_w'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_owner_lsu;
    logic                    w_owner_nxt;
    logic [c_streak_w-1:0]   r_streak;
    logic [c_streak_w-1:0]   w_streak_nxt;
    logic                    w_req;
    logic                    w_sel_lsu;
    logic                    w_resp;

    // ------------------------------------------------------------------------
    // Next-state, owner selection and bus request
    // ------------------------------------------------------------------------
    always_comb begin
        w_req       = 1'b0;
        w_sel_lsu   = r_owner_lsu;
        w_state_nxt = r_state;
        w_owner_nxt = r_owner_lsu;
        case (r_state)
            ST_IDLE: begin
                w_req     = if_req_i | lsu_req_i;
                // LSU wins ties unless fetch has already waited out its streak
                w_sel_lsu = lsu_req_i & ~(if_req_i & (r_streak == c_streak_max));
                if (w_req) begin
                    w_owner_nxt = w_sel_lsu;
                    w_state_nxt = mem_gnt_i ? ST_RESP : ST_ADDR;
                end
            end
            ST_ADDR: begin
                w_req = 1'b1;
                if (mem_gnt_i) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (mem_rvalid_i) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Held low while reset is asserted so no request leaks onto the bus
    assign mem_req_o = w_req & rst_n;

    assign if_gnt_o  = mem_req_o & mem_gnt_i & ~w_sel_lsu;
    assign lsu_gnt_o = mem_req_o & mem_gnt_i &  w_sel_lsu;

    // ------------------------------------------------------------------------
    // Bus payload mux; zero whenever no request is presented
    // ------------------------------------------------------------------------
    always_comb begin
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (mem_req_o) begin
            if (w_sel_lsu) begin
                mem_we_o    = lsu_we_i;
                mem_be_o    = lsu_be_i;
                mem_addr_o  = lsu_addr_i;
                mem_wdata_o = lsu_wdata_i;
            end else begin
                mem_be_o    = '1;
                mem_addr_o  = if_addr_i;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Response routing: only a response seen while waiting for one counts
    // ------------------------------------------------------------------------
    assign w_resp       = (r_state == ST_RESP) & mem_rvalid_i;
    assign if_rvalid_o  = w_resp & ~r_owner_lsu;
    assign lsu_rvalid_o = w_resp &  r_owner_lsu;
    assign if_rdata_o   = mem_rdata_i;
    assign lsu_rdata_o  = mem_rdata_i;

    // ------------------------------------------------------------------------
    // Consecutive LSU grants while fetch is waiting
    // ------------------------------------------------------------------------
    always_comb begin
        w_streak_nxt = r_streak;
        if (!if_req_i || if_gnt_o) begin
            w_streak_nxt = '0;
        end else if (lsu_gnt_o && (r_streak != c_streak_max)) begin
            w_streak_nxt = r_streak + c_streak_w'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_owner_lsu <= 1'b0;
            r_streak    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_owner_lsu <= w_owner_nxt;
            r_streak    <= w_streak_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Directed and randomized checks of mem_port_arbiter against a
//            transaction-level model of the arbitration rules.
// Revision : 1.0 - initial release
// ============================================================================

module tb_mem_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = DATA_W / 8;
    localparam int LIMIT  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_gnt_o, if_rvalid_o;
    logic [DATA_W-1:0] if_rdata_o;
    logic              lsu_req_i, lsu_we_i;
    logic [BE_W-1:0]   lsu_be_i;
    logic [ADDR_W-1:0] lsu_addr_i;
    logic [DATA_W-1:0] lsu_wdata_i;
    logic              lsu_gnt_o, lsu_rvalid_o;
    logic [DATA_W-1:0] lsu_rdata_o;
    logic              mem_req_o, mem_we_o;
    logic [BE_W-1:0]   mem_be_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic              mem_gnt_i, mem_rvalid_i;
    logic [DATA_W-1:0] mem_rdata_i;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_gnt_o    (if_gnt_o),
        .if_rvalid_o (if_rvalid_o),
        .if_rdata_o  (if_rdata_o),
        .lsu_req_i   (lsu_req_i),
        .lsu_we_i    (lsu_we_i),
        .lsu_be_i    (lsu_be_i),
        .lsu_addr_i  (lsu_addr_i),
        .lsu_wdata_i (lsu_wdata_i),
        .lsu_gnt_o   (lsu_gnt_o),
        .lsu_rvalid_o(lsu_rvalid_o),
        .lsu_rdata_o (lsu_rdata_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_be_o    (mem_be_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_gnt_i   (mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i (mem_rdata_i)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h time=%0t", name, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Transaction-level model: one in-flight transaction record plus the
    // number of LSU grants fetch has sat through.
    // ------------------------------------------------------------------------
    bit m_busy;          // a transaction has an owner
    bit m_accepted;      // its address phase has been accepted
    bit m_owner_lsu;
    int m_streak;
    bit e_if_gnt, e_lsu_gnt;

    always @(negedge clk) begin : compare
        logic e_req, e_sel, e_we, e_ifg, e_lsug, e_ifv, e_lsuv;
        logic [BE_W-1:0]   e_be;
        logic [ADDR_W-1:0] e_addr;
        logic [DATA_W-1:0] e_wdata;

        if (!rst_n) begin
            m_busy = 0; m_accepted = 0; m_owner_lsu = 0; m_streak = 0;
            e_req = 0; e_sel = 0;
        end else if (!m_busy) begin
            e_req = if_req_i | lsu_req_i;
            e_sel = lsu_req_i && !(if_req_i && m_streak == LIMIT);
        end else begin
            e_req = !m_accepted;
            e_sel = m_owner_lsu;
        end

        e_we = 0; e_be = '0; e_addr = '0; e_wdata = '0;
        if (e_req) begin
            e_we    = e_sel ? lsu_we_i    : 1'b0;
            e_be    = e_sel ? lsu_be_i    : '1;
            e_addr  = e_sel ? lsu_addr_i  : if_addr_i;
            e_wdata = e_sel ? lsu_wdata_i : '0;
        end
        e_ifg  = e_req && mem_gnt_i && !e_sel;
        e_lsug = e_req && mem_gnt_i &&  e_sel;
        e_ifv  = m_busy && m_accepted && mem_rvalid_i && !m_owner_lsu;
        e_lsuv = m_busy && m_accepted && mem_rvalid_i &&  m_owner_lsu;

        chk("mem_req",    32'(mem_req_o),    32'(e_req));
        chk("mem_we",     32'(mem_we_o),     32'(e_we));
        chk("mem_be",     32'(mem_be_o),     32'(e_be));
        chk("mem_addr",   mem_addr_o,        e_addr);
        chk("mem_wdata",  mem_wdata_o,       e_wdata);
        chk("if_gnt",     32'(if_gnt_o),     32'(e_ifg));
        chk("lsu_gnt",    32'(lsu_gnt_o),    32'(e_lsug));
        chk("if_rvalid",  32'(if_rvalid_o),  32'(e_ifv));
        chk("lsu_rvalid", 32'(lsu_rvalid_o), 32'(e_lsuv));
        chk("if_rdata",   if_rdata_o,        mem_rdata_i);
        chk("lsu_rdata",  lsu_rdata_o,       mem_rdata_i);

        if (rst_n) begin
            if (!m_busy) begin
                if (e_req) begin
                    m_busy = 1; m_owner_lsu = e_sel; m_accepted = mem_gnt_i;
                end
            end else if (!m_accepted) begin
                if (mem_gnt_i) m_accepted = 1;
            end else if (mem_rvalid_i) begin
                m_busy = 0;
            end
            if (!if_req_i || e_ifg) m_streak = 0;
            else if (e_lsug && m_streak < LIMIT) m_streak++;
        end
        e_if_gnt  = e_ifg;
        e_lsu_gnt = e_lsug;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Literal checks land mid-cycle, clear of both clock edges
    task automatic settle();
        #3;
    endtask

    initial begin : stim
        rst_n = 0;
        if_req_i = 0; if_addr_i = '0;
        lsu_req_i = 1; lsu_we_i = 0; lsu_be_i = 4'hF; lsu_addr_i = 32'h300; lsu_wdata_i = '0;
        mem_gnt_i = 1; mem_rvalid_i = 1; mem_rdata_i = '0;

        // Reset with LSU requesting: bus stays quiet
        tick(); settle();
        chk("rst_mem_req", 32'(mem_req_o), 0);
        chk("rst_gnts", {30'd0, if_gnt_o, lsu_gnt_o}, 0);
        chk("rst_rvalids", {30'd0, if_rvalid_o, lsu_rvalid_o}, 0);
        tick(); rst_n = 1; mem_gnt_i = 0; mem_rvalid_i = 0; settle();
        chk("post_rst_req", 32'(mem_req_o), 1);
        chk("post_rst_addr", mem_addr_o, 32'h300);
        tick(); mem_gnt_i = 1; settle();
        chk("post_rst_lsu_gnt", 32'(lsu_gnt_o), 1);
        tick(); lsu_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h55; settle();
        chk("post_rst_lsu_rvalid", 32'(lsu_rvalid_o), 1);
        tick(); mem_rvalid_i = 0;

        // Fetch alone, granted immediately, data next cycle
        tick(); if_req_i = 1; if_addr_i = 32'h100; mem_gnt_i = 1; settle();
        chk("if_only_gnt", 32'(if_gnt_o), 1);
        chk("if_only_addr", mem_addr_o, 32'h100);
        chk("if_only_be", 32'(mem_be_o), 32'hF);
        tick(); if_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hDEADBEEF; settle();
        chk("if_only_rvalid", 32'(if_rvalid_o), 1);
        chk("if_only_rdata", if_rdata_o, 32'hDEADBEEF);
        chk("if_only_lsu_rvalid", 32'(lsu_rvalid_o), 0);
        tick(); mem_rvalid_i = 0;

        // LSU store stalled three cycles while fetch waits
        tick();
        lsu_req_i = 1; lsu_we_i = 1; lsu_be_i = 4'b0011; lsu_addr_i = 32'h200; lsu_wdata_i = 32'h1234;
        if_req_i = 1; if_addr_i = 32'h400; mem_gnt_i = 0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                tick(); mem_gnt_i = (i == 3);
            end
            settle();
            chk("store_addr", mem_addr_o, 32'h200);
            chk("store_we", 32'(mem_we_o), 1);
            chk("store_be", 32'(mem_be_o), 32'h3);
            chk("store_wdata", mem_wdata_o, 32'h1234);
            chk("store_if_gnt", 32'(if_gnt_o), 0);
            chk("store_lsu_gnt", 32'(lsu_gnt_o), 32'(i == 3));
        end
        tick(); lsu_req_i = 0; mem_gnt_i = 1; mem_rvalid_i = 1; settle();
        chk("store_rvalid", 32'(lsu_rvalid_o), 1);
        chk("store_resp_if_gnt", 32'(if_gnt_o), 0);
        tick(); mem_rvalid_i = 0; settle();
        chk("after_store_if_gnt", 32'(if_gnt_o), 1);
        chk("after_store_if_addr", mem_addr_o, 32'h400);
        tick(); if_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; settle();
        chk("after_store_if_rvalid", 32'(if_rvalid_o), 1);
        tick(); mem_rvalid_i = 0;

        // Both requesting continuously: fetch gets every fifth grant
        tick();
        if_req_i = 1; if_addr_i = 32'h500;
        lsu_req_i = 1; lsu_we_i = 0; lsu_be_i = 4'hF; lsu_addr_i = 32'h600;
        mem_gnt_i = 1;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) begin
                tick(); mem_rvalid_i = 0;
            end
            settle();
            chk("grant_order", {30'd0, if_gnt_o, lsu_gnt_o}, (k % 5 == 4) ? 32'd2 : 32'd1);
            tick(); mem_rvalid_i = 1; settle();
            chk("resp_order", {30'd0, if_rvalid_o, lsu_rvalid_o}, (k % 5 == 4) ? 32'd2 : 32'd1);
        end
        tick(); mem_rvalid_i = 0; if_req_i = 0; lsu_req_i = 0; mem_gnt_i = 0;

        // Stray response in IDLE, then reset while a response is owed
        tick(); mem_rvalid_i = 1; settle();
        chk("stray_rvalids", {30'd0, if_rvalid_o, lsu_rvalid_o}, 0);
        tick(); mem_rvalid_i = 0; if_req_i = 1; lsu_req_i = 1; mem_gnt_i = 1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                tick(); mem_rvalid_i = 0;
            end
            settle();
            chk("pre_rst_lsu_gnt", 32'(lsu_gnt_o), 1);
            tick();
            if (k == 3) rst_n = 0;
            mem_rvalid_i = 1;
            settle();
        end
        chk("rst_in_resp_rvalids", {30'd0, if_rvalid_o, lsu_rvalid_o}, 0);
        chk("rst_in_resp_req", 32'(mem_req_o), 0);
        tick(); rst_n = 1; mem_rvalid_i = 0; settle();
        chk("post_rst_streak_lsu_wins", {30'd0, if_gnt_o, lsu_gnt_o}, 32'd1);
        tick(); mem_rvalid_i = 1; if_req_i = 0; lsu_req_i = 0; settle();
        chk("post_rst_resp", 32'(lsu_rvalid_o), 1);
        tick(); mem_rvalid_i = 0; mem_gnt_i = 0;

        // Randomized traffic, checked cycle by cycle by the model
        for (int n = 0; n < 4000; n++) begin
            tick();
            if (!rst_n) rst_n = 1;
            else if ($urandom_range(0, 499) == 0) rst_n = 0;
            if (!if_req_i || e_if_gnt) begin
                if_req_i  = ($urandom_range(0, 2) != 0);
                if_addr_i = $urandom;
            end
            if (!lsu_req_i || e_lsu_gnt) begin
                lsu_req_i   = ($urandom_range(0, 2) != 0);
                lsu_we_i    = 1'($urandom_range(0, 1));
                lsu_be_i    = 4'($urandom_range(0, 15));
                lsu_addr_i  = $urandom;
                lsu_wdata_i = $urandom;
            end
            mem_gnt_i = ($urandom_range(0, 3) != 0);
            if (m_busy && m_accepted) mem_rvalid_i = ($urandom_range(0, 2) == 0);
            else                      mem_rvalid_i = ($urandom_range(0, 15) == 0);
            mem_rdata_i = $urandom;
        end

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
